adaptive_filter_seq: RTL and testbench



---
 rtl/adaptive_pkg.sv | 30 +++
 rtl/adaptive_phase_cnt.sv | 37 +++
 rtl/adaptive_filter_seq.sv | 158 +++++++++++++++
 tb/tb_adaptive_filter_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/adaptive_pkg.sv
// Shared types and default constants for the adaptive filter frame sequencer.
package adaptive_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_FILT = 3'd1,
    ST_DIV  = 3'd2,
    ST_UPD  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam int NTAPS_DEF    = 32;
  localparam int FILT_CYC_DEF = 35;
  localparam int DIV_TMO_DEF  = 64;
  localparam int FCNT_W_DEF   = 16;
  localparam int IDX_W        = $clog2(NTAPS_DEF);
  localparam int CNT_W        = 8;

  // Counter preset on entry to a phase; the counter then runs down to zero.
  function automatic logic [CNT_W-1:0] phase_load(input state_e st, input int filt_cyc,
                                                   input int div_tmo, input int ntaps);
    case (st)
      ST_FILT: return CNT_W'(filt_cyc - 1);
      ST_DIV:  return CNT_W'(div_tmo - 1);
      ST_UPD:  return CNT_W'(ntaps - 1);
      default: return {CNT_W{1'b0}};
    endcase
  endfunction

endpackage

// File: rtl/adaptive_phase_cnt.sv
// Loadable down-counter with terminal flag; times the FILT, DIV-timeout and UPD phases.
module adaptive_phase_cnt
  import adaptive_pkg::*;
#(
  parameter int W = CNT_W
)(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         term_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != {W{1'b0}}) begin
      cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= {W{1'b0}};
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign term_o = (cnt_q == {W{1'b0}});

endmodule

// File: rtl/adaptive_filter_seq.sv
// Frame sequencer for the NLMS adaptive filter: IDLE -> FILT -> DIV -> UPD -> DONE per sample.
// Optional ADAPT_WARMUP_EN: suppress weight updates until the delay line has filled.
module adaptive_filter_seq
  import adaptive_pkg::*;
#(
  parameter int NTAPS    = NTAPS_DEF,
  parameter int FILT_CYC = FILT_CYC_DEF,
  parameter int DIV_TMO  = DIV_TMO_DEF,
  parameter int FCNT_W   = FCNT_W_DEF
)(
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     sample_valid_i,
  output logic                     sample_ready_o,
  input  logic                     abort_i,
  output logic                     filt_state_o,
  output logic                     div_state_o,
  output logic                     div_start_o,
  input  logic                     div_done_i,
  output logic                     upd_en_o,
  output logic [$clog2(NTAPS)-1:0] upd_idx_o,
  output logic                     upd_last_o,
  output logic                     frame_done_o,
  output logic                     div_err_o,
  output logic [FCNT_W-1:0]        frame_cnt_o,
`ifdef ADAPT_WARMUP_EN
  output logic                     warm_o,
`endif
  output logic                     busy_o
);

  localparam int IW = $clog2(NTAPS);

  state_e            state_q, state_d;
  logic              term_s, load_s, tmo_s, warm_s;
  logic [CNT_W-1:0]  load_val_s;
  logic [IW-1:0]     upd_idx_q, upd_idx_d;
  logic [FCNT_W-1:0] frame_cnt_q;
  logic              ready_q, filt_q, div_q, start_q, upd_q, last_q, done_q, err_q, busy_q;

  assign load_s     = (state_d != state_q);
  assign load_val_s = phase_load(state_d, FILT_CYC, DIV_TMO, NTAPS);

  adaptive_phase_cnt #(.W(CNT_W)) u_phase_cnt (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .load_i     (load_s),
    .load_val_i (load_val_s),
    .term_o     (term_s)
  );

  always_comb begin
    state_d = state_q;
    tmo_s   = 1'b0;
    case (state_q)
      ST_IDLE: if (sample_valid_i && ready_q && !abort_i) state_d = ST_FILT;
               else state_d = ST_IDLE;
      ST_FILT: if (abort_i) state_d = ST_IDLE;
               else if (term_s) state_d = ST_DIV;
               else state_d = ST_FILT;
      // div_done takes priority over a timeout landing in the same cycle
      ST_DIV: begin
        if (abort_i) state_d = ST_IDLE;
        else if (div_done_i) state_d = warm_s ? ST_UPD : ST_DONE;
        else if (term_s) begin
          state_d = ST_DONE;
          tmo_s   = 1'b1;
        end else state_d = ST_DIV;
      end
      ST_UPD:  if (abort_i) state_d = ST_IDLE;
               else if (term_s) state_d = ST_DONE;
               else state_d = ST_UPD;
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    if (state_d == ST_UPD && state_q == ST_UPD) upd_idx_d = upd_idx_q + IW'(1);
    else upd_idx_d = {IW{1'b0}};
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_IDLE;
      ready_q     <= 1'b1;
      filt_q      <= 1'b0;
      div_q       <= 1'b0;
      start_q     <= 1'b0;
      upd_q       <= 1'b0;
      upd_idx_q   <= {IW{1'b0}};
      last_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      busy_q      <= 1'b0;
      frame_cnt_q <= {FCNT_W{1'b0}};
    end else begin
      state_q   <= state_d;
      ready_q   <= (state_d == ST_IDLE);
      filt_q    <= (state_d == ST_FILT);
      div_q     <= (state_d == ST_DIV);
      start_q   <= (state_d == ST_DIV) && (state_q != ST_DIV);
      upd_q     <= (state_d == ST_UPD);
      upd_idx_q <= upd_idx_d;
      last_q    <= (state_d == ST_UPD) && (upd_idx_d == IW'(NTAPS - 1));
      done_q    <= (state_d == ST_DONE);
      busy_q    <= (state_d != ST_IDLE);
      err_q     <= err_q | tmo_s;
      if (state_d == ST_DONE && state_q != ST_DONE) frame_cnt_q <= frame_cnt_q + FCNT_W'(1);
      else frame_cnt_q <= frame_cnt_q;
    end
  end

`ifdef ADAPT_WARMUP_EN
  localparam int WW = $clog2(NTAPS + 3);
  localparam logic [WW-1:0] WARM_MAX = WW'(NTAPS + 2);

  logic [WW-1:0] warm_cnt_q, warm_cnt_d;
  logic          frame_warm_q, warm_q, accept_s;

  assign accept_s = (state_q == ST_IDLE) && (state_d == ST_FILT);
  assign warm_s   = frame_warm_q;

  always_comb begin
    warm_cnt_d = warm_cnt_q;
    if (accept_s && warm_cnt_q != WARM_MAX) warm_cnt_d = warm_cnt_q + WW'(1);
    else warm_cnt_d = warm_cnt_q;
  end

  // A frame is warm if the line was already full when its sample arrived
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      warm_cnt_q   <= {WW{1'b0}};
      frame_warm_q <= 1'b0;
      warm_q       <= 1'b0;
    end else begin
      warm_cnt_q   <= warm_cnt_d;
      frame_warm_q <= accept_s ? (warm_cnt_q == WARM_MAX) : frame_warm_q;
      warm_q       <= (state_d == ST_IDLE) ? (warm_cnt_d == WARM_MAX) : warm_q;
    end
  end

  assign warm_o = warm_q;
`else
  assign warm_s = 1'b1;
`endif

  assign sample_ready_o = ready_q;
  assign filt_state_o   = filt_q;
  assign div_state_o    = div_q;
  assign div_start_o    = start_q;
  assign upd_en_o       = upd_q;
  assign upd_idx_o      = upd_idx_q;
  assign upd_last_o     = last_q;
  assign frame_done_o   = done_q;
  assign div_err_o      = err_q;
  assign frame_cnt_o    = frame_cnt_q;
  assign busy_o         = busy_q;

endmodule

// File: tb/tb_adaptive_filter_seq.sv
// Directed bench for adaptive_filter_seq; frame counter narrowed to 4 bits so the wrap is reachable.
module tb_adaptive_filter_seq;

  logic       clk = 1'b0, rst = 1'b1, valid = 1'b0, abort = 1'b0, div_done = 1'b0;
  logic       ready, filt, divs, dstart, upd, ulast, fdone, derr, busy;
  logic [4:0] uidx;
  logic [3:0] fcnt;

  int cyc = 0, errors = 0, checks = 0;
  int filt_first, filt_last, filt_n, div_first, div_last, div_n, start_at, start_n;
  int upd_first, upd_last, upd_n, idx_bad, last_at, last_n, fd_at, fd_n, ovl;
  int err_at, ready_at;
  logic err_prev = 1'b0, rdy_prev = 1'b1;

  adaptive_filter_seq #(.FCNT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .sample_valid_i(valid), .sample_ready_o(ready),
    .abort_i(abort), .filt_state_o(filt), .div_state_o(divs), .div_start_o(dstart),
    .div_done_i(div_done), .upd_en_o(upd), .upd_idx_o(uidx), .upd_last_o(ulast),
    .frame_done_o(fdone), .div_err_o(derr), .frame_cnt_o(fcnt), .busy_o(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (filt) begin if (filt_n == 0) filt_first = cyc; filt_last = cyc; filt_n++; end
    if (divs) begin if (div_n == 0) div_first = cyc; div_last = cyc; div_n++; end
    if (dstart) begin start_at = cyc; start_n++; end
    if (upd) begin
      if (upd_n == 0) upd_first = cyc;
      if (uidx !== upd_n[4:0]) idx_bad++;
      upd_last = cyc; upd_n++;
    end
    if (ulast) begin last_at = cyc; last_n++; end
    if (fdone) begin fd_at = cyc; fd_n++; end
    if (int'(filt) + int'(divs) + int'(upd) > 1) ovl++;
    if (derr && !err_prev) err_at = cyc;
    if (ready && !rdy_prev) ready_at = cyc;
    err_prev = derr; rdy_prev = ready;
  end

  task automatic tick;
    @(posedge clk); #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) tick();
  endtask

  task automatic clear_mon;
    filt_first = 0; filt_last = 0; filt_n = 0; div_first = 0; div_last = 0; div_n = 0;
    start_at = 0; start_n = 0; upd_first = 0; upd_last = 0; upd_n = 0; idx_bad = 0;
    last_at = 0; last_n = 0; fd_at = 0; fd_n = 0; ovl = 0; err_at = 0; ready_at = 0;
  endtask

  task automatic do_frame(output int t0);
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 40); div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(t0 + 76);
  endtask

  task automatic test_reset;
    clear_mon();
    tick(); tick();
    if (ready !== 1'b1) begin $display("FAIL rst_ready: got %b exp 1", ready); errors++; end checks++;
    if ({filt, divs, dstart, upd, ulast, fdone, derr, busy} !== 8'h00) begin
      $display("FAIL rst_outputs: got %b exp 00000000", {filt, divs, dstart, upd, ulast, fdone, derr, busy}); errors++; end checks++;
    if (fcnt !== 4'd0 || uidx !== 5'd0) begin $display("FAIL rst_counts: got fcnt=%0d idx=%0d exp 0 0", fcnt, uidx); errors++; end checks++;
    rst = 1'b0; tick();
    if (ready !== 1'b1 || busy !== 1'b0) begin $display("FAIL rst_idle: got ready=%b busy=%b exp 1 0", ready, busy); errors++; end checks++;
  endtask

  task automatic test_main;
    int t0;
    clear_mon();
    wait_cyc(10);
    if (ready !== 1'b1) begin $display("FAIL main_ready_pre: got %b exp 1", ready); errors++; end checks++;
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    if (ready !== 1'b0 || busy !== 1'b1) begin $display("FAIL main_accept: got ready=%b busy=%b exp 0 1", ready, busy); errors++; end checks++;
    wait_cyc(50); div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(86);
    if (filt_first !== 11 || filt_last !== 45 || filt_n !== 35) begin
      $display("FAIL main_filt: got %0d..%0d n=%0d exp 11..45 n=35", filt_first, filt_last, filt_n); errors++; end checks++;
    if (start_at !== 46 || start_n !== 1) begin $display("FAIL main_div_start: got at=%0d n=%0d exp 46 1", start_at, start_n); errors++; end checks++;
    if (div_first !== 46 || div_last !== 50) begin $display("FAIL main_div_win: got %0d..%0d exp 46..50", div_first, div_last); errors++; end checks++;
    if (upd_first !== 51 || upd_last !== 82 || upd_n !== 32) begin
      $display("FAIL main_upd: got %0d..%0d n=%0d exp 51..82 n=32", upd_first, upd_last, upd_n); errors++; end checks++;
    if (idx_bad !== 0) begin $display("FAIL main_upd_idx: got %0d bad exp 0", idx_bad); errors++; end checks++;
    if (last_at !== 82 || last_n !== 1) begin $display("FAIL main_upd_last: got at=%0d n=%0d exp 82 1", last_at, last_n); errors++; end checks++;
    if (fd_at !== 83 || fd_n !== 1) begin $display("FAIL main_frame_done: got at=%0d n=%0d exp 83 1", fd_at, fd_n); errors++; end checks++;
    if (fcnt !== 4'd1) begin $display("FAIL main_frame_cnt: got %0d exp 1", fcnt); errors++; end checks++;
    if (ready_at !== 84) begin $display("FAIL main_ready_back: got %0d exp 84", ready_at); errors++; end checks++;
    if (ovl !== 0 || derr !== 1'b0) begin $display("FAIL main_misc: got ovl=%0d err=%b exp 0 0", ovl, derr); errors++; end checks++;
    if (t0 !== 10) begin $display("FAIL main_t0: got %0d exp 10", t0); errors++; end checks++;
  endtask

  task automatic test_timeout;
    int t0;
    clear_mon();
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 104);
    if (div_first !== t0 + 36 || div_last !== t0 + 99 || div_n !== 64) begin
      $display("FAIL tmo_div_win: got %0d..%0d n=%0d exp %0d..%0d n=64", div_first, div_last, div_n, t0 + 36, t0 + 99); errors++; end checks++;
    if (err_at !== t0 + 100 || derr !== 1'b1) begin $display("FAIL tmo_div_err: got at=%0d val=%b exp %0d 1", err_at, derr, t0 + 100); errors++; end checks++;
    if (fd_at !== t0 + 100 || fd_n !== 1) begin $display("FAIL tmo_frame_done: got at=%0d n=%0d exp %0d 1", fd_at, fd_n, t0 + 100); errors++; end checks++;
    if (upd_n !== 0) begin $display("FAIL tmo_no_upd: got %0d exp 0", upd_n); errors++; end checks++;
    if (fcnt !== 4'd2) begin $display("FAIL tmo_frame_cnt: got %0d exp 2", fcnt); errors++; end checks++;
  endtask

  task automatic test_abort;
    int t0;
    clear_mon();
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 10); abort = 1'b1; tick(); abort = 1'b0;
    if (filt !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) begin
      $display("FAIL abort_filt_drop: got filt=%b busy=%b ready=%b exp 0 0 1", filt, busy, ready); errors++; end checks++;
    wait_cyc(t0 + 120);
    if (fd_n !== 0 || div_n !== 0 || fcnt !== 4'd2 || derr !== 1'b1) begin
      $display("FAIL abort_filt_after: got fd=%0d div=%0d fcnt=%0d err=%b exp 0 0 2 1", fd_n, div_n, fcnt, derr); errors++; end checks++;
    abort = 1'b1; valid = 1'b1; tick(); abort = 1'b0; valid = 1'b0; tick();
    if (busy !== 1'b0) begin $display("FAIL abort_idle_no_accept: got busy=%b exp 0", busy); errors++; end checks++;
    clear_mon();
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 40); div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(t0 + 50); abort = 1'b1; tick(); abort = 1'b0;
    if (upd !== 1'b0 || busy !== 1'b0 || upd_n !== 10) begin
      $display("FAIL abort_upd: got upd=%b busy=%b n=%0d exp 0 0 10", upd, busy, upd_n); errors++; end checks++;
    wait_cyc(t0 + 80);
    if (fd_n !== 0 || fcnt !== 4'd2) begin $display("FAIL abort_upd_after: got fd=%0d fcnt=%0d exp 0 2", fd_n, fcnt); errors++; end checks++;
    clear_mon();
    do_frame(t0);
    if (fd_at !== t0 + 73 || upd_n !== 32 || fcnt !== 4'd3) begin
      $display("FAIL abort_next_frame: got fd=%0d upd=%0d fcnt=%0d exp %0d 32 3", fd_at, upd_n, fcnt, t0 + 73); errors++; end checks++;
  endtask

  task automatic test_spurious;
    int t0;
    clear_mon();
    div_done = 1'b1; tick(); div_done = 1'b0; tick();
    if (busy !== 1'b0 || div_n !== 0) begin $display("FAIL spur_idle: got busy=%b div=%0d exp 0 0", busy, div_n); errors++; end checks++;
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 5);  div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(t0 + 40); div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(t0 + 50); div_done = 1'b1; tick(); div_done = 1'b0;
    wait_cyc(t0 + 76);
    if (filt_n !== 35 || div_first !== t0 + 36 || div_last !== t0 + 40 || start_n !== 1) begin
      $display("FAIL spur_filt_div: got filt=%0d div=%0d..%0d start=%0d exp 35 %0d..%0d 1", filt_n, div_first, div_last, start_n, t0 + 36, t0 + 40); errors++; end checks++;
    if (upd_n !== 32 || last_at !== t0 + 72 || idx_bad !== 0 || fd_at !== t0 + 73) begin
      $display("FAIL spur_upd: got n=%0d last=%0d bad=%0d fd=%0d exp 32 %0d 0 %0d", upd_n, last_at, idx_bad, fd_at, t0 + 72, t0 + 73); errors++; end checks++;
    if (fcnt !== 4'd4 || ovl !== 0) begin $display("FAIL spur_cnt: got fcnt=%0d ovl=%0d exp 4 0", fcnt, ovl); errors++; end checks++;
  endtask

  task automatic test_back_to_back;
    int g;
    clear_mon();
    valid = 1'b1;
    for (int f = 0; f < 12; f++) begin
      g = 0;
      while (!dstart && g < 200) begin tick(); g++; end
      if (g >= 200) begin $display("FAIL b2b_div_start_wait: got timeout frame %0d exp div_start", f); errors++; end checks++;
      div_done = 1'b1; tick(); div_done = 1'b0;
      g = 0;
      while (!fdone && g < 200) begin tick(); g++; end
      if (g >= 200) begin $display("FAIL b2b_done_wait: got timeout frame %0d exp frame_done", f); errors++; end checks++;
    end
    valid = 1'b0;
    tick(); tick();
    if (fcnt !== 4'd0) begin $display("FAIL b2b_wrap: got %0d exp 0", fcnt); errors++; end checks++;
    if (fd_n !== 12 || upd_n !== 384 || filt_n !== 420 || idx_bad !== 0 || busy !== 1'b0) begin
      $display("FAIL b2b_totals: got fd=%0d upd=%0d filt=%0d bad=%0d busy=%b exp 12 384 420 0 0", fd_n, upd_n, filt_n, idx_bad, busy); errors++; end checks++;
  endtask

  task automatic test_reset_mid;
    int t0;
    clear_mon();
    valid = 1'b1; t0 = cyc; tick(); valid = 1'b0;
    wait_cyc(t0 + 38);
    if (divs !== 1'b1 || derr !== 1'b1) begin $display("FAIL rstmid_pre: got div=%b err=%b exp 1 1", divs, derr); errors++; end checks++;
    rst = 1'b1; tick();
    if ({filt, divs, dstart, upd, ulast, fdone, derr, busy} !== 8'h00 || ready !== 1'b1 || fcnt !== 4'd0) begin
      $display("FAIL rstmid_vals: got %b ready=%b fcnt=%0d exp 00000000 1 0", {filt, divs, dstart, upd, ulast, fdone, derr, busy}, ready, fcnt); errors++; end checks++;
    rst = 1'b0; tick();
    clear_mon();
    do_frame(t0);
    if (fd_at !== t0 + 73 || fcnt !== 4'd1 || derr !== 1'b0) begin
      $display("FAIL rstmid_restart: got fd=%0d fcnt=%0d err=%b exp %0d 1 0", fd_at, fcnt, derr, t0 + 73); errors++; end checks++;
  endtask

  initial begin
    test_reset();
    test_main();
    test_timeout();
    test_abort();
    test_spurious();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
